// File: rtl/rs_scheduler.sv
// Reservation-station bank for one functional unit.
// Holds dispatched instructions and captures their missing operands from
// the CDB. Each cycle it presents the oldest entry whose operands are both
// valid. Ages form a dense rank: 0 is the oldest busy entry. An issue
// decrements every younger entry's age, so the relative order is preserved.
//
// Handshake: iss_valid/iss_ready is a strict valid/ready pair. Once
// iss_valid rises for an entry, that entry and all iss_* fields stay fixed
// until the cycle in which iss_ready is high. The transfer happens on that
// clock edge. iss_valid never depends combinationally on iss_ready,
// dis_* or cdb_*.
module rs_scheduler #(
  parameter int NUM_RS     = 4,
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          dis_valid,
  output logic                          dis_ready,
  input  logic [3:0]                    dis_op,
  input  logic [data_width-1:0]         dis_Vj,
  input  logic [data_width-1:0]         dis_Vk,
  input  logic [tag_width-1:0]          dis_Qj,
  input  logic [tag_width-1:0]          dis_Qk,
  input  logic                          dis_Vj_valid,
  input  logic                          dis_Vk_valid,
  input  logic [tag_width-1:0]          dis_dest,
  input  logic                          cdb_valid,
  input  logic [tag_width-1:0]          cdb_tag,
  input  logic [data_width-1:0]         cdb_data,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [3:0]                    iss_op,
  output logic [data_width-1:0]         iss_Vj,
  output logic [data_width-1:0]         iss_Vk,
  output logic [tag_width-1:0]          iss_dest,
  output logic [$clog2(NUM_RS+1)-1:0]   occupancy
);
  localparam int AW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int OW = $clog2(NUM_RS+1);

  logic [NUM_RS-1:0]     busy_q, busy_d, vjv_q, vjv_d, vkv_q, vkv_d;
  logic [3:0]            op_q   [NUM_RS];
  logic [3:0]            op_d   [NUM_RS];
  logic [data_width-1:0] vj_q   [NUM_RS];
  logic [data_width-1:0] vj_d   [NUM_RS];
  logic [data_width-1:0] vk_q   [NUM_RS];
  logic [data_width-1:0] vk_d   [NUM_RS];
  logic [tag_width-1:0]  qj_q   [NUM_RS];
  logic [tag_width-1:0]  qj_d   [NUM_RS];
  logic [tag_width-1:0]  qk_q   [NUM_RS];
  logic [tag_width-1:0]  qk_d   [NUM_RS];
  logic [tag_width-1:0]  dest_q [NUM_RS];
  logic [tag_width-1:0]  dest_d [NUM_RS];
  logic [AW-1:0]         age_q  [NUM_RS];
  logic [AW-1:0]         age_d  [NUM_RS];
  logic                  lock_q, lock_d;
  logic [AW-1:0]         lock_idx_q, lock_idx_d;

  logic [OW-1:0] occ;
  logic [AW-1:0] alloc_idx, oldest_idx, sel, best_age;
  logic          alloc_found, any_rdy;
  logic          do_dis, do_iss, byp_j, byp_k;

  // Occupancy, lowest free slot and oldest ready entry, all from registered state
  always_comb begin
    occ         = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    oldest_idx  = '0;
    best_age    = '0;
    any_rdy     = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      occ = occ + OW'(busy_q[i]);
      if (!busy_q[i] && !alloc_found) begin
        alloc_idx   = AW'(i);
        alloc_found = 1'b1;
      end
      if (busy_q[i] && vjv_q[i] && vkv_q[i] && (!any_rdy || age_q[i] < best_age)) begin
        oldest_idx = AW'(i);
        best_age   = age_q[i];
        any_rdy    = 1'b1;
      end
    end
  end

  assign occupancy = occ;
  assign dis_ready = (occ < OW'(NUM_RS));
  // A locked entry is always ready: it is busy and its operands cannot be un-validated
  assign sel       = lock_q ? lock_idx_q : oldest_idx;
  assign iss_valid = lock_q | any_rdy;
  assign iss_op    = iss_valid ? op_q[sel]   : '0;
  assign iss_Vj    = iss_valid ? vj_q[sel]   : '0;
  assign iss_Vk    = iss_valid ? vk_q[sel]   : '0;
  assign iss_dest  = iss_valid ? dest_q[sel] : '0;

  assign do_dis = dis_valid && dis_ready && !flush;
  assign do_iss = iss_valid && iss_ready;
  assign byp_j  = !dis_Vj_valid && cdb_valid && (cdb_tag == dis_Qj);
  assign byp_k  = !dis_Vk_valid && cdb_valid && (cdb_tag == dis_Qk);

  // Next state: flush, CDB wakeup, issue/lock, then dispatch into the free slot
  always_comb begin
    busy_d     = busy_q;
    vjv_d      = vjv_q;
    vkv_d      = vkv_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    dest_d     = dest_q;
    age_d      = age_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush) begin
      busy_d = '0;
      lock_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (busy_q[i] && cdb_valid && !vjv_q[i] && qj_q[i] == cdb_tag) begin
          vj_d[i]  = cdb_data;
          vjv_d[i] = 1'b1;
        end
        if (busy_q[i] && cdb_valid && !vkv_q[i] && qk_q[i] == cdb_tag) begin
          vk_d[i]  = cdb_data;
          vkv_d[i] = 1'b1;
        end
      end
      if (do_iss) begin
        busy_d[sel] = 1'b0;
        lock_d      = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
          if (busy_q[i] && age_q[i] > age_q[sel]) age_d[i] = age_q[i] - AW'(1);
        end
      end else if (iss_valid) begin
        lock_d     = 1'b1;
        lock_idx_d = sel;
      end
      if (do_dis) begin
        busy_d[alloc_idx] = 1'b1;
        op_d[alloc_idx]   = dis_op;
        vj_d[alloc_idx]   = byp_j ? cdb_data : dis_Vj;
        vk_d[alloc_idx]   = byp_k ? cdb_data : dis_Vk;
        vjv_d[alloc_idx]  = dis_Vj_valid | byp_j;
        vkv_d[alloc_idx]  = dis_Vk_valid | byp_k;
        qj_d[alloc_idx]   = dis_Qj;
        qk_d[alloc_idx]   = dis_Qk;
        dest_d[alloc_idx] = dis_dest;
        age_d[alloc_idx]  = do_iss ? AW'(occ - OW'(1)) : AW'(occ);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      vjv_q      <= '0;
      vkv_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      vjv_q      <= vjv_d;
      vkv_q      <= vkv_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      dest_q     <= dest_d;
      age_q      <= age_d;
    end
  end
endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed scenarios followed by random traffic. The
// reference model holds the busy entries as a queue in dispatch order.
module tb_rs_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          flush, dis_valid, dis_ready, dis_Vj_valid, dis_Vk_valid;
  logic [3:0]    dis_op, iss_op;
  logic [DW-1:0] dis_Vj, dis_Vk, cdb_data, iss_Vj, iss_Vk;
  logic [TW-1:0] dis_Qj, dis_Qk, dis_dest, cdb_tag, iss_dest;
  logic          cdb_valid, iss_valid, iss_ready;
  logic [2:0]    occupancy;

  rs_scheduler #(.NUM_RS(N), .data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_op(dis_op),
    .dis_Vj(dis_Vj), .dis_Vk(dis_Vk), .dis_Qj(dis_Qj), .dis_Qk(dis_Qk),
    .dis_Vj_valid(dis_Vj_valid), .dis_Vk_valid(dis_Vk_valid), .dis_dest(dis_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_Vj(iss_Vj), .iss_Vk(iss_Vk), .iss_dest(iss_dest), .occupancy(occupancy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: entries in age order, oldest at index 0
  typedef struct {
    int            id;
    logic [3:0]    op;
    logic [DW-1:0] vj, vk;
    logic [TW-1:0] qj, qk, dest;
    bit            vjv, vkv;
  } ent_t;
  ent_t mq[$];
  bit   m_lock;
  int   m_lock_id;
  int   next_id;

  function automatic int m_pres();
    if (m_lock) begin
      for (int i = 0; i < mq.size(); i++) if (mq[i].id == m_lock_id) return i;
      return -1;
    end
    for (int i = 0; i < mq.size(); i++) if (mq[i].vjv && mq[i].vkv) return i;
    return -1;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_lock = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int   p, sz;
    ent_t e;
    if (!rst_n) begin m_reset(); return; end
    if (flush)  begin m_reset(); return; end
    p  = m_pres();
    sz = mq.size();
    for (int i = 0; i < sz; i++) begin
      if (cdb_valid && !mq[i].vjv && mq[i].qj == cdb_tag) begin mq[i].vj = cdb_data; mq[i].vjv = 1; end
      if (cdb_valid && !mq[i].vkv && mq[i].qk == cdb_tag) begin mq[i].vk = cdb_data; mq[i].vkv = 1; end
    end
    if (p >= 0) begin
      if (iss_ready) begin mq.delete(p); m_lock = 1'b0; end
      else begin m_lock = 1'b1; m_lock_id = mq[p].id; end
    end
    if (dis_valid && sz < N) begin
      e.id   = next_id++;
      e.op   = dis_op;
      e.qj   = dis_Qj;
      e.qk   = dis_Qk;
      e.dest = dis_dest;
      e.vjv  = dis_Vj_valid || (cdb_valid && cdb_tag == dis_Qj);
      e.vkv  = dis_Vk_valid || (cdb_valid && cdb_tag == dis_Qk);
      e.vj   = (!dis_Vj_valid && cdb_valid && cdb_tag == dis_Qj) ? cdb_data : dis_Vj;
      e.vk   = (!dis_Vk_valid && cdb_valid && cdb_tag == dis_Qk) ? cdb_data : dis_Vk;
      mq.push_back(e);
    end
  endtask

  // Scoreboard comparison primitive
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic compare();
    int p;
    p = m_pres();
    check("dis_ready", 32'(dis_ready), 32'(mq.size() < N));
    check("occupancy", 32'(occupancy), 32'(mq.size()));
    check("iss_valid", 32'(iss_valid), 32'(p >= 0));
    if (p >= 0) begin
      check("iss_op",   32'(iss_op),   32'(mq[p].op));
      check("iss_Vj",   32'(iss_Vj),   32'(mq[p].vj));
      check("iss_Vk",   32'(iss_Vk),   32'(mq[p].vk));
      check("iss_dest", 32'(iss_dest), 32'(mq[p].dest));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Driver tasks
  task automatic drive_idle();
    flush = 0; dis_valid = 0; dis_op = 0; dis_Vj = 0; dis_Vk = 0;
    dis_Qj = 0; dis_Qk = 0; dis_Vj_valid = 0; dis_Vk_valid = 0; dis_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; iss_ready = 0;
  endtask

  task automatic drive_dis(input logic [3:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                           input logic vjv, input logic vkv, input logic [TW-1:0] qj,
                           input logic [TW-1:0] qk, input logic [TW-1:0] dest);
    dis_valid = 1; dis_op = op; dis_Vj = vj; dis_Vk = vk; dis_Vj_valid = vjv;
    dis_Vk_valid = vkv; dis_Qj = qj; dis_Qk = qk; dis_dest = dest;
  endtask

  task automatic drive_cdb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
  endtask

  initial begin
    next_id = 0;
    m_reset();
    drive_idle();
    // Reset: held low for three cycles
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare();
    check("rst_dis_ready", 32'(dis_ready), 32'd1);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_iss_fields", {iss_op, iss_dest, iss_Vj[11:0], iss_Vk[12:0]}, 32'd0);

    // Simple issue
    drive_dis(4'h1, 16'h0005, 16'h0003, 1, 1, 0, 0, 3'd2);
    iss_ready = 1;
    tick();
    check("simple_iss_valid", 32'(iss_valid), 32'd1);
    check("simple_iss_Vj",    32'(iss_Vj),    32'h0005);
    check("simple_iss_Vk",    32'(iss_Vk),    32'h0003);
    check("simple_iss_dest",  32'(iss_dest),  32'd2);
    check("simple_model_sz",  32'(mq.size()), 32'd1);
    dis_valid = 0;
    tick();
    check("simple_occ_after", 32'(occupancy), 32'd0);

    // Wakeup from the CDB two cycles after dispatch
    drive_dis(4'h5, 16'h0000, 16'h0007, 0, 1, 3'd4, 0, 3'd3);
    tick();
    check("wake_pending0", 32'(iss_valid), 32'd0);
    dis_valid = 0;
    tick();
    check("wake_pending1", 32'(iss_valid), 32'd0);
    drive_cdb(3'd4, 16'h1234);
    tick();
    check("wake_iss_valid", 32'(iss_valid), 32'd1);
    check("wake_iss_Vj",    32'(iss_Vj),    32'h1234);
    cdb_valid = 0;
    tick();

    // Same-cycle bypass
    drive_dis(4'h5, 16'h0000, 16'h0009, 0, 1, 3'd4, 0, 3'd1);
    drive_cdb(3'd4, 16'hbeef);
    tick();
    check("byp_iss_valid", 32'(iss_valid), 32'd1);
    check("byp_iss_Vj",    32'(iss_Vj),    32'hbeef);
    dis_valid = 0; cdb_valid = 0;
    tick();
    check("byp_empty", 32'(occupancy), 32'd0);

    // Oldest-first with lock, and full behaviour
    iss_ready = 0;
    for (int i = 0; i < N; i++) begin
      drive_dis(4'h1, 16'h0000, 16'(16'h0100 + i), 0, 1, TW'(i), 0, TW'(i));
      tick();
    end
    check("full_occ",       32'(occupancy), 32'd4);
    check("full_dis_ready", 32'(dis_ready), 32'd0);
    drive_dis(4'h2, 16'h0, 16'h0, 1, 1, 0, 0, 3'd7);
    tick();
    check("full_ignored_occ", 32'(occupancy), 32'd4);
    dis_valid = 0;
    drive_cdb(3'd3, 16'h0033);
    tick();
    check("lock_first_valid", 32'(iss_valid), 32'd1);
    check("lock_first_dest",  32'(iss_dest),  32'd3);
    drive_cdb(3'd0, 16'h0030);
    tick();
    check("lock_hold_dest", 32'(iss_dest), 32'd3);
    check("lock_hold_Vj",   32'(iss_Vj),   32'h0033);
    cdb_valid = 0;
    iss_ready = 1;
    tick();
    check("lock_next_dest",  32'(iss_dest),  32'd0);
    check("lock_next_occ",   32'(occupancy), 32'd3);
    check("freed_dis_ready", 32'(dis_ready), 32'd1);
    drive_dis(4'h3, 16'h0011, 16'h0022, 1, 1, 0, 0, 3'd5);
    tick();
    check("dis_iss_same_occ", 32'(occupancy), 32'd3);
    dis_valid = 0; iss_ready = 0; flush = 1;
    tick();
    check("flush_occ",       32'(occupancy), 32'd0);
    check("flush_iss_valid", 32'(iss_valid), 32'd0);
    flush = 0;

    // Asynchronous reset while an entry is presented
    drive_dis(4'h1, 16'h0001, 16'h0002, 1, 1, 0, 0, 3'd6);
    tick();
    dis_valid = 0;
    check("pre_rst_iss_valid", 32'(iss_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_iss_valid", 32'(iss_valid), 32'd0);
    check("async_rst_occ",       32'(occupancy), 32'd0);
    m_reset();
    #1 rst_n = 1'b1;
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      flush        = ($urandom_range(0, 99) < 2);
      dis_valid    = ($urandom_range(0, 99) < 60);
      dis_op       = 4'($urandom);
      dis_Vj       = 16'($urandom);
      dis_Vk       = 16'($urandom);
      dis_Qj       = 3'($urandom);
      dis_Qk       = 3'($urandom);
      dis_Vj_valid = 1'($urandom_range(0, 1));
      dis_Vk_valid = 1'($urandom_range(0, 1));
      dis_dest     = 3'($urandom);
      cdb_valid    = ($urandom_range(0, 99) < 50);
      cdb_tag      = 3'($urandom);
      cdb_data     = 16'($urandom);
      iss_ready    = ($urandom_range(0, 99) < 50);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_scheduler.md
# rs_scheduler

Controller for a bank of reservation-station entries in front of one functional unit of the out-of-order LC-3b core. It accepts dispatched instructions into free entries and snoops the common data bus (CDB) to capture pending operands. It issues the oldest entry whose operands are both valid to the functional unit over a valid/ready handshake, then frees that entry. It owns all per-entry state: busy, op, Vj/Vk, Qj/Qk, valid bits, destination tag and age.

## Interface
- NUM_RS, 4: number of entries, 2..8.
- data_width, 16: operand width.
- tag_width, 3: ROB tag width.
- clk  in  1  clock. One clock domain; everything is sampled on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- flush  in  1  synchronous clear of all entries (mispredict).
- dis_valid  in  1  dispatch request.
- dis_ready  out  1  at least one entry is free.
- dis_op  in  4  lc3b_opcode.
- dis_Vj, dis_Vk  in  data_width  operand values.
- dis_Qj, dis_Qk  in  tag_width  producer tags. Used when the matching valid bit is 0.
- dis_Vj_valid, dis_Vk_valid  in  1  operand already available.
- dis_dest  in  tag_width  ROB tag of the result.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  tag_width  tag being broadcast.
- cdb_data  in  data_width  value being broadcast.
- iss_valid  out  1  an entry is presented to the functional unit.
- iss_ready  in  1  the functional unit accepts the presented entry.
- iss_op  out  4  opcode of the presented entry.
- iss_Vj, iss_Vk  out  data_width  operands of the presented entry.
- iss_dest  out  tag_width  destination tag of the presented entry.
- occupancy  out  $clog2(NUM_RS+1)  count of busy entries.

## Operation
**Entry state**
- Each entry holds: busy, op, Vj, Vk, Qj, Qk, Vj_valid, Vk_valid, dest, and age.
- An entry is ready when busy=1, Vj_valid=1 and Vk_valid=1.

**Dispatch**
- A dispatch is accepted when dis_valid && dis_ready && !flush.
- The instruction is written into the lowest-index free entry, and busy is set.
- The entry gets the youngest age.

**Dispatch bypass**
- If dis_Vj_valid=0, cdb_valid=1 and cdb_tag==dis_Qj in the same cycle, the entry stores cdb_data with Vj_valid=1.
- The same rule applies to the k operand.

**Wakeup**
- Applies to every busy entry with a pending operand (valid=0) whose Q equals cdb_tag while cdb_valid=1.
- That operand latches cdb_data and its valid bit is set at the clock edge.
- Both operands may wake on the same broadcast.

**Select**
- Among ready entries, the oldest is presented.
- Ages are unique, so there is never a tie.

**Issue lock**
- Once iss_valid is asserted for entry X, X remains presented until iss_ready=1, even if an older entry becomes ready in the meantime.
- iss_* outputs are stable while iss_valid && !iss_ready.

**Issue completion**
- iss_valid && iss_ready clears busy for X at the edge and releases the lock.
- The remaining entries keep their relative age order.

**Flush and reset**
- flush clears all busy bits and the lock, and ignores same-cycle dispatch and CDB.
- Data fields need not be cleared.
- Reset (rst_n=0) clears all state immediately, without waiting for a clock edge.

## Timing
**Reset values**
- dis_ready=1, iss_valid=0, occupancy=0.
- iss_op, iss_Vj, iss_Vk and iss_dest are all 0.

**Derivation of outputs**
- dis_ready = occupancy < NUM_RS. It is derived from registered busy bits only.
- An entry freed by issue in cycle t is allocatable in cycle t+1, not t.
- iss_* are derived from registered state only. There is no combinational path from dis_* or cdb_* to iss_*.

**Latencies**
- Dispatch at edge t with both operands valid: iss_valid can be asserted in cycle t+1, at the earliest.
- CDB wakeup at edge t: the entry is eligible in cycle t+1.
- A bypass-captured operand behaves as valid at dispatch.

**Simultaneous events**
- Dispatch and issue in the same cycle: both take effect.
- occupancy is unchanged in that case.

**Full and empty**
- When full, dis_valid is ignored and no state changes from dispatch.
- When empty, iss_valid=0.

**Reset mid-handshake**
- A reset asserted while iss_valid=1 drops iss_valid immediately.

## Test plan
- **Reset:** rst_n low for 3 cycles, then high → dis_ready=1, iss_valid=0, occupancy=0.
- **Simple issue:**
  - Dispatch op=ADD, Vj=0x0005, Vk=0x0003, both valid, dest=2, with iss_ready=1.
  - Next cycle: iss_valid=1, iss_Vj=0x0005, iss_Vk=0x0003, iss_dest=2.
  - Following cycle: occupancy=0.
- **Wakeup:**
  - Dispatch with Qj=4, Vj_valid=0, Vk valid.
  - Two cycles later, broadcast cdb_tag=4, cdb_data=0x1234.
  - Next cycle: iss_valid=1 with iss_Vj=0x1234. iss_valid was 0 before that.
  - Same-cycle bypass (CDB tag 4 during dispatch): issue in the next cycle.
- **Oldest-first and lock:**
  - Fill 4 entries with all operands pending; keep iss_ready=0.
  - Wake entry 3 (the youngest) → it is presented.
  - Then wake entry 0 (the oldest) → entry 3 is still presented.
  - Assert iss_ready → entry 0 is presented next.
- **Full:**
  - 4 dispatches → dis_ready=0, and a 5th dis_valid is ignored (occupancy=4).
  - Issue one → dis_ready=1 one cycle later.
  - Dispatch plus issue in the same cycle → occupancy steady.
- **Flush and async reset:**
  - flush with 3 busy entries → occupancy=0 and iss_valid=0 at the next cycle.
  - rst_n pulsed low between edges while iss_valid=1 → iss_valid=0 before the next edge.
